regfile_scoreboard: RTL and testbench

//  Parametrised CPU register file for the pipelined LC-3 datapath.
//  - 1 write port, 2 combinational read ports, write-to-read bypass.
//  - Per-register pending (scoreboard) bits: set on instruction issue, cleared on writeback.
//  - Reports read-after-write hazards to the control unit.
//  - Sits between decode (sources, DR) and writeback (bus).

---
 rtl/lc3_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 26 ++
 rtl/regfile_scoreboard.sv | 98 +++++++++
 tb/tb_regfile_scoreboard.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath widths and types used by the register file and its read ports.
package lc3_pkg;

    localparam int REG_W     = 16;
    localparam int NREGS     = 8;
    localparam int NRD_PORTS = 2;

    typedef logic [REG_W-1:0]          word_t;
    typedef logic [$clog2(NREGS)-1:0]  regaddr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: address mux, writeback bypass and hazard flag.
module regfile_read_port
    import lc3_pkg::*;
#(
    parameter int WIDTH = REG_W,
    parameter int NREGS = lc3_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [NREGS-1:0]            pend,
    input  logic [AW-1:0]               addr,
    input  logic                        wb_valid,
    input  logic [AW-1:0]               wb_dr,
    input  logic [WIDTH-1:0]            wb_data,
    output logic [WIDTH-1:0]            data,
    output logic                        busy
);

    logic byp;

    // A writeback to the same register both supplies the data and resolves the hazard.
    assign byp  = wb_valid && (wb_dr == addr);
    assign data = byp ? wb_data : regs[addr];
    assign busy = pend[addr] & ~byp;

endmodule

// File: rtl/regfile_scoreboard.sv
// LC-3 register file with write-to-read bypass and per-register pending bits for RAW hazard stalls.
module regfile_scoreboard #(
    parameter  int WIDTH = lc3_pkg::REG_W,
    parameter  int NREGS = lc3_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic             iss_wr,
    input  logic [AW-1:0]    iss_dr,
    input  logic [AW-1:0]    sr1_addr,
    input  logic [AW-1:0]    sr2_addr,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_dr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic             sr1_busy,
    output logic             sr2_busy,
    output logic             stall,
    output logic [AW:0]      pend_cnt
);

    import lc3_pkg::*;

    localparam logic [AW:0] CNT_ONE = 1;

    logic [NREGS-1:0][WIDTH-1:0]     regs;
    logic [NREGS-1:0]                pend;
    logic [NREGS-1:0]                set_vec;
    logic [NREGS-1:0]                clr_vec;
    logic                            cnt_inc;
    logic                            cnt_dec;

    logic [NRD_PORTS-1:0][AW-1:0]    rd_addr;
    logic [NRD_PORTS-1:0][WIDTH-1:0] rd_data;
    logic [NRD_PORTS-1:0]            rd_busy;

    assign rd_addr  = {sr2_addr, sr1_addr};
    assign sr1_out  = rd_data[0];
    assign sr2_out  = rd_data[1];
    assign sr1_busy = rd_busy[0];
    assign sr2_busy = rd_busy[1];
    assign stall    = iss_valid & (|rd_busy);

    for (genvar p = 0; p < NRD_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .WIDTH (WIDTH),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd (
            .regs     (regs),
            .pend     (pend),
            .addr     (rd_addr[p]),
            .wb_valid (wb_valid),
            .wb_dr    (wb_dr),
            .wb_data  (wb_data),
            .data     (rd_data[p]),
            .busy     (rd_busy[p])
        );
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && iss_wr && !stall)
            set_vec[iss_dr] = 1'b1;
        if (wb_valid)
            clr_vec[wb_dr] = 1'b1;
    end

    // Count moves only on real bit transitions; a same-register issue shadows its writeback.
    assign cnt_inc = |(set_vec & ~pend);
    assign cnt_dec = |(clr_vec & pend & ~set_vec);

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '0;
        end else if (wb_valid) begin
            regs[wb_dr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend <= set_vec | (pend & ~clr_vec);
            if (cnt_inc && !cnt_dec)
                pend_cnt <= pend_cnt + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                pend_cnt <= pend_cnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table followed by random traffic checked against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_wr, wb_valid;
    logic [2:0]  iss_dr, sr1_addr, sr2_addr, wb_dr;
    logic [15:0] wb_data;
    logic [15:0] sr1_out, sr2_out;
    logic        sr1_busy, sr2_busy, stall;
    logic [3:0]  pend_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] mreg [8];
    bit          mpend[8];

    typedef struct {
        logic        rst, iv, iw;
        logic [2:0]  dr, s1, s2;
        logic        wv;
        logic [2:0]  wd;
        logic [15:0] wdat, e1, e2;
        logic        b1, b2, st;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[26];

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dr(iss_dr),
        .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
        .sr1_out(sr1_out), .sr2_out(sr2_out),
        .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst;
        iss_valid = v.iv;
        iss_wr    = v.iw;
        iss_dr    = v.dr;
        sr1_addr  = v.s1;
        sr2_addr  = v.s2;
        wb_valid  = v.wv;
        wb_dr     = v.wd;
        wb_data   = v.wdat;
    endtask

    // Reference model: the specification's read/busy rules over plain arrays.
    task automatic model_expect(output vec_t e);
        bit byp1, byp2;
        int c;
        e    = '{default: '0};
        byp1 = wb_valid && (wb_dr == sr1_addr);
        byp2 = wb_valid && (wb_dr == sr2_addr);
        e.e1 = byp1 ? wb_data : mreg[sr1_addr];
        e.e2 = byp2 ? wb_data : mreg[sr2_addr];
        e.b1 = mpend[sr1_addr] && !byp1;
        e.b2 = mpend[sr2_addr] && !byp2;
        e.st = iss_valid && (e.b1 || e.b2);
        c = 0;
        for (int r = 0; r < 8; r++) c += int'(mpend[r]);
        e.cnt = 4'(c);
    endtask

    task automatic model_edge(input bit stalled);
        if (!reset) begin
            for (int r = 0; r < 8; r++) begin
                mreg[r]  = '0;
                mpend[r] = 1'b0;
            end
        end else begin
            if (wb_valid) begin
                mreg[wb_dr]  = wb_data;
                mpend[wb_dr] = 1'b0;
            end
            if (iss_valid && iss_wr && !stalled)
                mpend[iss_dr] = 1'b1;
        end
    endtask

    task automatic compare(input vec_t e, input string tag);
        check({tag, ".sr1_out"},  sr1_out,           e.e1);
        check({tag, ".sr2_out"},  sr2_out,           e.e2);
        check({tag, ".sr1_busy"}, {15'd0, sr1_busy}, {15'd0, e.b1});
        check({tag, ".sr2_busy"}, {15'd0, sr2_busy}, {15'd0, e.b2});
        check({tag, ".stall"},    {15'd0, stall},    {15'd0, e.st});
        check({tag, ".pend_cnt"}, {12'd0, pend_cnt}, {12'd0, e.cnt});
    endtask

    initial begin
        vec_t me, rv;
        bit   st;

        tbl[0]  = '{1,0,0,0,3,5,1,3,16'hBEEF, 16'hBEEF,16'h0000,0,0,0,0};
        tbl[1]  = '{1,0,0,0,3,5,1,5,16'h1234, 16'hBEEF,16'h1234,0,0,0,0};
        tbl[2]  = '{1,1,1,2,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,0};
        tbl[3]  = '{1,1,1,6,2,0,0,0,16'h0000, 16'h0000,16'h0000,1,0,1,1};
        tbl[4]  = '{1,1,0,7,2,6,1,2,16'h0ABC, 16'h0ABC,16'h0000,0,0,0,1};
        tbl[5]  = '{1,0,0,0,2,6,0,0,16'h0000, 16'h0ABC,16'h0000,0,0,0,0};
        tbl[6]  = '{1,1,1,4,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,0};
        tbl[7]  = '{1,1,1,4,4,4,1,4,16'h5555, 16'h5555,16'h5555,0,0,0,1};
        tbl[8]  = '{1,0,0,0,4,3,0,0,16'h0000, 16'h5555,16'hBEEF,1,0,0,1};
        tbl[9]  = '{1,1,1,0,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,1};
        tbl[10] = '{1,1,1,1,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,2};
        tbl[11] = '{1,1,1,2,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,3};
        tbl[12] = '{1,1,1,3,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,4};
        tbl[13] = '{1,1,1,4,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,5};
        tbl[14] = '{1,1,1,5,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,5};
        tbl[15] = '{1,1,1,6,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,6};
        tbl[16] = '{1,1,1,7,7,7,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,7};
        tbl[17] = '{1,1,1,7,7,7,1,7,16'h0F0F, 16'h0F0F,16'h0F0F,0,0,0,8};
        tbl[18] = '{1,0,0,0,7,0,0,0,16'h0000, 16'h0F0F,16'h0000,1,1,0,8};
        tbl[19] = '{0,1,1,1,7,1,1,1,16'hFFFF, 16'h0F0F,16'hFFFF,1,0,1,8};
        tbl[20] = '{1,0,0,0,7,4,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,0};
        tbl[21] = '{1,1,1,3,3,5,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,0};
        tbl[22] = '{1,1,1,5,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,1};
        tbl[23] = '{1,1,1,6,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,2};
        tbl[24] = '{0,0,0,0,3,5,0,0,16'h0000, 16'h0000,16'h0000,1,1,0,3};
        tbl[25] = '{1,0,0,0,3,6,0,0,16'h0000, 16'h0000,16'h0000,0,0,0,0};

        drive('{default: '0});
        for (int r = 0; r < 8; r++) begin
            mreg[r]  = '0;
            mpend[r] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < $size(tbl); i++) begin
            drive(tbl[i]);
            #1;
            compare(tbl[i], $sformatf("vec%0d", i));
            model_expect(me);
            @(posedge clk);
            model_edge(me.st);
            @(negedge clk);
        end

        // Random traffic, with occasional resets landing on whatever state has built up.
        for (int i = 0; i < 3000; i++) begin
            rv      = '{default: '0};
            rv.rst  = ($urandom_range(0, 39) != 0);
            rv.iv   = $urandom_range(0, 1);
            rv.iw   = ($urandom_range(0, 3) != 0);
            rv.dr   = 3'($urandom_range(0, 7));
            rv.s1   = 3'($urandom_range(0, 7));
            rv.s2   = 3'($urandom_range(0, 7));
            rv.wv   = ($urandom_range(0, 2) != 0);
            rv.wd   = 3'($urandom_range(0, 7));
            rv.wdat = 16'($urandom);
            drive(rv);
            #1;
            model_expect(me);
            compare(me, "rand");
            st = me.st;
            @(posedge clk);
            model_edge(st);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
